// File: rtl/rgb_process_pkg.sv
// Shared types and constants for the rgb_process pixel pipeline.
// Edge detection is built only when RGB_PROCESS_EDGE_EN is defined.
package rgb_process_pkg;

  typedef enum logic [1:0] {
    PASS = 2'b00,
    GRAY = 2'b01,
    EDGE = 2'b10,
    INV  = 2'b11
  } mode_e;

  localparam int unsigned H_ACTIVE          = 640;
  localparam int unsigned V_ACTIVE          = 480;
  localparam int unsigned DEF_BRIGHT_OFFSET = 64;
  localparam int unsigned DEF_EDGE_THRESH   = 32;

  // 8-bit add that clamps at full scale instead of wrapping
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/rgb_process_luma.sv
// Combinational luma: Y = (R + 2G + B) >> 2, formed at 10 bits so it cannot overflow.
module rgb_luma (
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] y
);

  logic [9:0] sum;

  // weighted sum then divide by four
  always_comb begin
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    y   = 8'(sum >> 2);
  end

endmodule

// File: rtl/rgb_process.sv
// Single-cycle RGB pixel processor: mode transform, brightness, channel
// suppress, then active-window blanking, all registered on CLOCK_50.
// Optional feature macro: RGB_PROCESS_EDGE_EN (edge mode); when undefined,
// mode 10 falls back to grayscale and no Yprev/comparator exists.
module rgb_process
  import rgb_process_pkg::*;
#(
  parameter int unsigned BRIGHT_OFFSET = DEF_BRIGHT_OFFSET,
  parameter int unsigned EDGE_THRESH   = DEF_EDGE_THRESH
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        Icontrol1,
  input  logic        Icontrol2,
  input  logic        rIenable,
  input  logic        gIenable,
  input  logic        bIenable,
  input  logic        brightLevel,
  input  logic [7:0]  raw_VGA_R,
  input  logic [7:0]  raw_VGA_G,
  input  logic [7:0]  raw_VGA_B,
  input  logic [12:0] row,
  input  logic [12:0] col,
  output logic [7:0]  o_VGA_R,
  output logic [7:0]  o_VGA_G,
  output logic [7:0]  o_VGA_B
);

  localparam logic [7:0] BOFF = 8'(BRIGHT_OFFSET);

  mode_e      mode;
  logic [7:0] luma;
  logic [7:0] r_v, g_v, b_v;
  logic       apply_bright;
  logic [7:0] out_r_d, out_g_d, out_b_d;
  logic [7:0] out_r_q, out_g_q, out_b_q;

  assign mode = mode_e'({Icontrol2, Icontrol1});

  rgb_luma u_luma (
    .r (raw_VGA_R),
    .g (raw_VGA_G),
    .b (raw_VGA_B),
    .y (luma)
  );

`ifdef RGB_PROCESS_EDGE_EN
  localparam logic [8:0] THRESH9 = 9'(EDGE_THRESH);

  logic [7:0] yprev_d, yprev_q;
  logic [7:0] diff;
  logic       edge_hit;

  // luma difference against the previous pixel; line start never counts
  always_comb begin
    yprev_d  = luma;
    diff     = (luma >= yprev_q) ? (luma - yprev_q) : (yprev_q - luma);
    if (col == '0) diff = '0;
    edge_hit = ({1'b0, diff} >= THRESH9);
  end
`endif

  // transform -> brightness -> suppress -> window blank
  always_comb begin
    r_v = raw_VGA_R;
    g_v = raw_VGA_G;
    b_v = raw_VGA_B;
    unique case (mode)
      PASS: ;
      GRAY: begin r_v = luma; g_v = luma; b_v = luma; end
`ifdef RGB_PROCESS_EDGE_EN
      EDGE: begin
        r_v = edge_hit ? '1 : '0;
        g_v = r_v;
        b_v = r_v;
      end
`else
      EDGE: begin r_v = luma; g_v = luma; b_v = luma; end
`endif
      INV:  begin r_v = ~raw_VGA_R; g_v = ~raw_VGA_G; b_v = ~raw_VGA_B; end
    endcase

`ifdef RGB_PROCESS_EDGE_EN
    apply_bright = brightLevel && (mode != EDGE);
`else
    apply_bright = brightLevel;
`endif
    if (apply_bright) begin
      r_v = sat_add8(r_v, BOFF);
      g_v = sat_add8(g_v, BOFF);
      b_v = sat_add8(b_v, BOFF);
    end

    out_r_d = rIenable ? '0 : r_v;
    out_g_d = gIenable ? '0 : g_v;
    out_b_d = bIenable ? '0 : b_v;

    // unsigned compare also catches wrapped negative coordinates
    if (col >= 13'(H_ACTIVE) || row >= 13'(V_ACTIVE)) begin
      out_r_d = '0;
      out_g_d = '0;
      out_b_d = '0;
    end
  end

  // output register (and Yprev when edge mode is built)
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      out_r_q <= '0;
      out_g_q <= '0;
      out_b_q <= '0;
`ifdef RGB_PROCESS_EDGE_EN
      yprev_q <= '0;
`endif
    end else begin
      out_r_q <= out_r_d;
      out_g_q <= out_g_d;
      out_b_q <= out_b_d;
`ifdef RGB_PROCESS_EDGE_EN
      yprev_q <= yprev_d;
`endif
    end
  end

  assign o_VGA_R = out_r_q;
  assign o_VGA_G = out_g_q;
  assign o_VGA_B = out_b_q;

endmodule

// File: tb/tb_rgb_process.sv
// Directed self-checking bench for rgb_process; edge-mode expectations
// follow whether RGB_PROCESS_EDGE_EN is defined for the build.
module tb_rgb_process;

`ifdef RGB_PROCESS_EDGE_EN
  localparam bit EDGE_ON = 1'b1;
`else
  localparam bit EDGE_ON = 1'b0;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic        Icontrol1, Icontrol2;
  logic        rIenable, gIenable, bIenable;
  logic        brightLevel;
  logic [7:0]  raw_VGA_R, raw_VGA_G, raw_VGA_B;
  logic [12:0] row, col;
  logic [7:0]  o_VGA_R, o_VGA_G, o_VGA_B;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  rgb_process #(.BRIGHT_OFFSET(64), .EDGE_THRESH(32)) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .Icontrol1   (Icontrol1),
    .Icontrol2   (Icontrol2),
    .rIenable    (rIenable),
    .gIenable    (gIenable),
    .bIenable    (bIenable),
    .brightLevel (brightLevel),
    .raw_VGA_R   (raw_VGA_R),
    .raw_VGA_G   (raw_VGA_G),
    .raw_VGA_B   (raw_VGA_B),
    .row         (row),
    .col         (col),
    .o_VGA_R     (o_VGA_R),
    .o_VGA_G     (o_VGA_G),
    .o_VGA_B     (o_VGA_B)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Apply one pixel, clock it, then check the registered outputs #1 later.
  task automatic step(input string tag, input logic rst_n, input logic [1:0] mode,
                      input logic [2:0] sup, input logic bright,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [12:0] rw, input logic [12:0] cl,
                      input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    RESET_N     = rst_n;
    Icontrol2   = mode[1];
    Icontrol1   = mode[0];
    rIenable    = sup[2];
    gIenable    = sup[1];
    bIenable    = sup[0];
    brightLevel = bright;
    raw_VGA_R   = r;
    raw_VGA_G   = g;
    raw_VGA_B   = b;
    row         = rw;
    col         = cl;
    @(posedge CLOCK_50);
    #1;
    checks++;
    assert (o_VGA_R === er) else begin
      failures++;
      $error("FAIL %s R got=%0d exp=%0d", tag, o_VGA_R, er);
    end
    checks++;
    assert (o_VGA_G === eg) else begin
      failures++;
      $error("FAIL %s G got=%0d exp=%0d", tag, o_VGA_G, eg);
    end
    checks++;
    assert (o_VGA_B === eb) else begin
      failures++;
      $error("FAIL %s B got=%0d exp=%0d", tag, o_VGA_B, eb);
    end
  endtask

  logic [7:0] e;

  initial begin
    // reset holds outputs at zero regardless of input
    step("reset", 1'b0, 2'b00, 3'b000, 1'b0, 8'd10, 8'd20, 8'd30, 13'd5, 13'd5, 8'd0, 8'd0, 8'd0);

    // pass-through, first sample after reset release
    step("pass", 1'b1, 2'b00, 3'b000, 1'b0, 8'd10, 8'd20, 8'd30, 13'd5, 13'd5, 8'd10, 8'd20, 8'd30);

    // grayscale: Y = (100 + 100 + 200) / 4 = 100
    step("gray", 1'b1, 2'b01, 3'b000, 1'b0, 8'd100, 8'd50, 8'd200, 13'd5, 13'd5, 8'd100, 8'd100, 8'd100);
    step("gray_bright", 1'b1, 2'b01, 3'b000, 1'b1, 8'd100, 8'd50, 8'd200, 13'd5, 13'd5, 8'd164, 8'd164, 8'd164);
    step("gray_sat", 1'b1, 2'b01, 3'b000, 1'b1, 8'd250, 8'd250, 8'd250, 13'd5, 13'd5, 8'd255, 8'd255, 8'd255);

    // edge sequence (falls back to grayscale + brightness when not built)
    e = EDGE_ON ? 8'd0 : 8'd10;
    step("edge_col0", 1'b1, 2'b10, 3'b000, 1'b0, 8'd10, 8'd10, 8'd10, 13'd5, 13'd0, e, e, e);
    e = EDGE_ON ? 8'd255 : 8'd60;
    step("edge_col1", 1'b1, 2'b10, 3'b000, 1'b0, 8'd60, 8'd60, 8'd60, 13'd5, 13'd1, e, e, e);
    e = EDGE_ON ? 8'd0 : 8'd134;
    step("edge_col2_bright", 1'b1, 2'b10, 3'b000, 1'b1, 8'd70, 8'd70, 8'd70, 13'd5, 13'd2, e, e, e);
    e = EDGE_ON ? 8'd255 : 8'd200;
    step("edge_col5", 1'b1, 2'b10, 3'b000, 1'b0, 8'd200, 8'd200, 8'd200, 13'd5, 13'd5, e, e, e);
    e = EDGE_ON ? 8'd0 : 8'd20;
    step("edge_line_start", 1'b1, 2'b10, 3'b000, 1'b0, 8'd20, 8'd20, 8'd20, 13'd6, 13'd0, e, e, e);

    // invert with green suppressed
    step("inv_gsup", 1'b1, 2'b11, 3'b010, 1'b0, 8'd0, 8'd0, 8'd255, 13'd5, 13'd5, 8'd255, 8'd0, 8'd0);
    // invert -> bright (255/219/69) -> red suppressed
    step("inv_bright_rsup", 1'b1, 2'b11, 3'b100, 1'b1, 8'd0, 8'd100, 8'd250, 13'd5, 13'd5, 8'd0, 8'd219, 8'd69);

    // window edges
    step("win_last", 1'b1, 2'b00, 3'b000, 1'b0, 8'd10, 8'd20, 8'd30, 13'd479, 13'd639, 8'd10, 8'd20, 8'd30);
    step("win_col640", 1'b1, 2'b00, 3'b000, 1'b0, 8'd10, 8'd20, 8'd30, 13'd5, 13'd640, 8'd0, 8'd0, 8'd0);
    step("win_row8191", 1'b1, 2'b11, 3'b000, 1'b1, 8'd10, 8'd20, 8'd30, 13'd8191, 13'd5, 8'd0, 8'd0, 8'd0);
    step("win_row480", 1'b1, 2'b01, 3'b000, 1'b0, 8'd10, 8'd20, 8'd30, 13'd480, 13'd5, 8'd0, 8'd0, 8'd0);

    // mid-stream reset clears Yprev: 40 vs 0 is an edge, 40 vs 40 would not be
    e = EDGE_ON ? 8'd0 : 8'd40;
    step("pre_reset", 1'b1, 2'b10, 3'b000, 1'b0, 8'd40, 8'd40, 8'd40, 13'd7, 13'd2, e, e, e);
    step("mid_reset", 1'b0, 2'b10, 3'b000, 1'b0, 8'd200, 8'd200, 8'd200, 13'd7, 13'd3, 8'd0, 8'd0, 8'd0);
    e = EDGE_ON ? 8'd255 : 8'd40;
    step("post_reset_edge", 1'b1, 2'b10, 3'b000, 1'b0, 8'd40, 8'd40, 8'd40, 13'd7, 13'd3, e, e, e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
